// File: rtl/can_control_field_tx.sv
// ============================================================================
// Module  : can_control_field_tx
// Brief   : CAN control-field serializer (base/extended, classic/FD, 6/8/9 bits).
//           Optional macro CAN_CTRL_DLC_DECODE_EN adds the data_bytes output.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module can_control_field_tx #(
    parameter int FD_SUPPORT = 1,
    parameter int IDX_W      = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             start,
    input  logic             sample_point,
    input  logic             stuff_bit_inserted,
    input  logic             ide,
    input  logic             fdf,
    input  logic             brs,
    input  logic             esi,
    input  logic [3:0]       dlc,
    output logic             control_bit,
    output logic [IDX_W-1:0] bit_index,
    output logic             busy,
    output logic             brs_switch,
    output logic             control_complete
`ifdef CAN_CTRL_DLC_DECODE_EN
    ,
    output logic [6:0]       data_bytes
`endif
);

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_load  = 2'd1;
    localparam logic [1:0] c_shift = 2'd2;
    localparam logic [1:0] c_done  = 2'd3;
    localparam logic       c_fd_en = (FD_SUPPORT != 0);

    logic [1:0]       r_state;
    logic [8:0]       r_shift;
    logic [3:0]       r_len;
    logic             r_ide;
    logic             r_fdf;
    logic             r_brs;
    logic             r_esi;
    logic [3:0]       r_dlc;

    logic [8:0]       w_pattern;
    logic [3:0]       w_len;
    logic             w_advance;
    logic             w_last;
    logic [IDX_W-1:0] w_brs_pos;

    // Field image left-aligned in 9 bits, unused tail filled with recessive 1s.
    always_comb begin
        w_pattern = 9'h1FF;
        w_len     = 4'd6;
        case ({r_fdf, r_ide})
            2'b10: begin
                w_pattern = {1'b0, 1'b1, 1'b0, r_brs, r_esi, r_dlc};
                w_len     = 4'd9;
            end
            2'b11: begin
                w_pattern = {1'b1, 1'b0, r_brs, r_esi, r_dlc, 1'b1};
                w_len     = 4'd8;
            end
            default: begin
                w_pattern = {2'b00, r_dlc, 3'b111};
                w_len     = 4'd6;
            end
        endcase
    end

    assign w_advance = sample_point & ~stuff_bit_inserted;
    assign w_last    = (bit_index == IDX_W'(r_len - 4'd1));
    assign w_brs_pos = r_ide ? IDX_W'(2) : IDX_W'(3);
    assign busy      = (r_state == c_load) || (r_state == c_shift);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state          <= c_idle;
            r_shift          <= '1;
            r_len            <= 4'd6;
            {r_ide, r_fdf, r_brs, r_esi} <= 4'b0000;
            r_dlc            <= 4'd0;
            control_bit      <= 1'b1;
            bit_index        <= '0;
            brs_switch       <= 1'b0;
            control_complete <= 1'b0;
        end else if (!enable) begin
            r_state          <= c_idle;
            r_shift          <= '1;
            r_len            <= 4'd6;
            {r_ide, r_fdf, r_brs, r_esi} <= 4'b0000;
            r_dlc            <= 4'd0;
            control_bit      <= 1'b1;
            bit_index        <= '0;
            brs_switch       <= 1'b0;
            control_complete <= 1'b0;
        end else begin
            brs_switch       <= 1'b0;
            control_complete <= 1'b0;
            case (r_state)
                c_idle: begin
                    if (start) begin
                        r_ide   <= ide;
                        r_fdf   <= fdf & c_fd_en;
                        r_brs   <= brs;
                        r_esi   <= esi;
                        r_dlc   <= dlc;
                        r_state <= c_load;
                    end
                end
                c_load: begin
                    r_shift     <= w_pattern;
                    r_len       <= w_len;
                    control_bit <= w_pattern[8];
                    bit_index   <= '0;
                    r_state     <= c_shift;
                end
                c_shift: begin
                    if (w_advance) begin
                        if (w_last) begin
                            r_state          <= c_done;
                            control_complete <= 1'b1;
                            control_bit      <= 1'b1;
                            r_shift          <= '1;
                        end else begin
                            r_shift     <= {r_shift[7:0], 1'b1};
                            control_bit <= r_shift[7];
                            bit_index   <= bit_index + IDX_W'(1);
                        end
                        if (r_fdf && r_brs && (bit_index == w_brs_pos)) begin
                            brs_switch <= 1'b1;
                        end
                    end
                end
                c_done: begin
                    bit_index <= '0;
                    r_state   <= c_idle;
                end
                default: r_state <= c_idle;
            endcase
        end
    end

`ifdef CAN_CTRL_DLC_DECODE_EN
    function automatic logic [6:0] decode_bytes(input logic is_fd, input logic [3:0] code);
        logic [6:0] n;
        n = {3'b000, code};
        if (!is_fd) begin
            if (code > 4'd8) n = 7'd8;
        end else begin
            case (code)
                4'd9:    n = 7'd12;
                4'd10:   n = 7'd16;
                4'd11:   n = 7'd20;
                4'd12:   n = 7'd24;
                4'd13:   n = 7'd32;
                4'd14:   n = 7'd48;
                4'd15:   n = 7'd64;
                default: n = {3'b000, code};
            endcase
        end
        return n;
    endfunction

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            data_bytes <= 7'd0;
        end else if (!enable) begin
            data_bytes <= 7'd0;
        end else if (r_state == c_load) begin
            data_bytes <= decode_bytes(r_fdf, r_dlc);
        end
    end
`else
    // Payload-length decode not built in this configuration.
`endif

endmodule

`default_nettype wire

// File: tb/tb_can_control_field_tx.sv
// ============================================================================
// Module  : tb_can_control_field_tx
// Brief   : Randomized self-checking bench against a list-based field model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_can_control_field_tx;

    localparam int IDX_W = 4;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset_n, enable, sample_point, stuff_bit_inserted;
    logic ide, fdf, brs, esi;
    logic [3:0] dlc;
    logic start [0:1];
    logic cb [0:1];
    logic [IDX_W-1:0] bi [0:1];
    logic bz [0:1];
    logic bs [0:1];
    logic cc [0:1];
`ifdef CAN_CTRL_DLC_DECODE_EN
    logic [6:0] db [0:1];
`endif

    can_control_field_tx #(.FD_SUPPORT(1), .IDX_W(IDX_W)) dut_fd (
        .clock(clock), .reset_n(reset_n), .enable(enable), .start(start[0]),
        .sample_point(sample_point), .stuff_bit_inserted(stuff_bit_inserted),
        .ide(ide), .fdf(fdf), .brs(brs), .esi(esi), .dlc(dlc),
        .control_bit(cb[0]), .bit_index(bi[0]), .busy(bz[0]),
        .brs_switch(bs[0]), .control_complete(cc[0])
`ifdef CAN_CTRL_DLC_DECODE_EN
        , .data_bytes(db[0])
`endif
    );

    can_control_field_tx #(.FD_SUPPORT(0), .IDX_W(IDX_W)) dut_cl (
        .clock(clock), .reset_n(reset_n), .enable(enable), .start(start[1]),
        .sample_point(sample_point), .stuff_bit_inserted(stuff_bit_inserted),
        .ide(ide), .fdf(fdf), .brs(brs), .esi(esi), .dlc(dlc),
        .control_bit(cb[1]), .bit_index(bi[1]), .busy(bz[1]),
        .brs_switch(bs[1]), .control_complete(cc[1])
`ifdef CAN_CTRL_DLC_DECODE_EN
        , .data_bytes(db[1])
`endif
    );

    int checks = 0;
    int failures = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic int exp_bytes(input bit fd, input bit [3:0] d);
        if (!fd) return (d > 4'd8) ? 8 : int'(d);
        case (d)
            4'd9:    return 12;
            4'd10:   return 16;
            4'd11:   return 20;
            4'd12:   return 24;
            4'd13:   return 32;
            4'd14:   return 48;
            4'd15:   return 64;
            default: return int'(d);
        endcase
    endfunction

    task automatic check_idle(input int sel, input string tag);
        check_val({tag, "_cbit"}, 32'(cb[sel]), 1);
        check_val({tag, "_idx"}, 32'(bi[sel]), 0);
        check_val({tag, "_busy"}, 32'(bz[sel]), 0);
        check_val({tag, "_brs"}, 32'(bs[sel]), 0);
        check_val({tag, "_cmpl"}, 32'(cc[sel]), 0);
    endtask

    // sel 0 = FD-capable instance, sel 1 = classic-only instance.
    task automatic run_frame(input int sel, input bit f_ide, input bit f_fdf, input bit f_brs,
                             input bit f_esi, input bit [3:0] f_dlc, input bit directed,
                             input logic [31:0] stuff_mask, input int abort_after,
                             output logic [8:0] seq, output int strobes, output int brs_pulses);
        bit fd;
        bit q[$];
        int brs_pos, idx, adv_cnt, cyc;
        bit done, sp, st, adv, exp_c, exp_b;
        fd = f_fdf && (sel == 0);
        brs_pos = -1;
        if (!fd) begin
            q.push_back(1'b0);
            q.push_back(1'b0);
        end else begin
            if (!f_ide) q.push_back(1'b0);
            q.push_back(1'b1);
            q.push_back(1'b0);
            brs_pos = q.size();
            q.push_back(f_brs);
            q.push_back(f_esi);
        end
        for (int i = 3; i >= 0; i--) q.push_back(f_dlc[i]);

        ide = f_ide; fdf = f_fdf; brs = f_brs; esi = f_esi; dlc = f_dlc;
        start[sel] = 1'b1;
        tick();
        start[sel] = 1'b0;
        {ide, fdf, brs, esi, dlc} = 8'($urandom);
        check_val("load_busy", 32'(bz[sel]), 1);
        tick();
        check_val("first_bit", 32'(cb[sel]), 32'(q[0]));
        check_val("first_idx", 32'(bi[sel]), 0);
`ifdef CAN_CTRL_DLC_DECODE_EN
        check_val("data_bytes", 32'(db[sel]), 32'(exp_bytes(fd, f_dlc)));
`endif
        idx = 0; seq = '0; strobes = 0; brs_pulses = 0; adv_cnt = 0; cyc = 0; done = 1'b0;
        while (!done && cyc < 200) begin
            cyc++;
            if (directed) begin
                sp = (cyc % 2 == 1);
                st = sp && stuff_mask[strobes];
            end else begin
                sp = ($urandom_range(0, 2) == 0);
                st = sp && ($urandom_range(0, 3) == 0);
            end
            sample_point = sp;
            stuff_bit_inserted = st;
            start[sel] = 1'($urandom_range(0, 1));
            adv = sp && !st;
            exp_c = adv && (idx == q.size() - 1);
            exp_b = adv && fd && f_brs && (idx == brs_pos);
            if (adv) seq = {seq[7:0], cb[sel]};
            if (sp) strobes++;
            if (adv && !exp_c) idx++;
            tick();
            sample_point = 1'b0;
            stuff_bit_inserted = 1'b0;
            start[sel] = 1'b0;
            if (bs[sel] === 1'b1) brs_pulses++;
            check_val("complete", 32'(cc[sel]), 32'(exp_c));
            check_val("brs_switch", 32'(bs[sel]), 32'(exp_b));
            if (exp_c) begin
                done = 1'b1;
                check_val("done_cbit", 32'(cb[sel]), 1);
                check_val("done_busy", 32'(bz[sel]), 0);
            end else begin
                check_val("cbit", 32'(cb[sel]), 32'(q[idx]));
                check_val("idx", 32'(bi[sel]), 32'(idx));
                check_val("busy", 32'(bz[sel]), 1);
            end
            if (adv) begin
                adv_cnt++;
                if (abort_after != 0 && adv_cnt == abort_after) return;
            end
        end
        if (!done) check_val("frame_timeout", 0, 1);
        tick();
        check_idle(sel, "post");
    endtask

    logic [8:0] seq;
    int strobes, pulses;

    initial begin
        reset_n = 1'b0; enable = 1'b1; start[0] = 1'b0; start[1] = 1'b0;
        sample_point = 1'b0; stuff_bit_inserted = 1'b0;
        ide = 1'b0; fdf = 1'b0; brs = 1'b0; esi = 1'b0; dlc = 4'd0;
        tick();
        tick();
        check_idle(0, "rst0");
        check_idle(1, "rst1");
        reset_n = 1'b1;
        tick();

        run_frame(0, 0, 0, 0, 0, 4'b1010, 1, 32'd0, 0, seq, strobes, pulses);
        check_val("bc_seq", 32'(seq[5:0]), 32'b001010);
        check_val("bc_brs", 32'(pulses), 0);
        check_val("bc_strobes", 32'(strobes), 6);

        run_frame(0, 1, 1, 1, 0, 4'hF, 1, 32'd0, 0, seq, strobes, pulses);
        check_val("efd_seq", 32'(seq[7:0]), 32'b10101111);
        check_val("efd_brs", 32'(pulses), 1);

        run_frame(0, 0, 1, 0, 1, 4'b0110, 1, 32'b10010, 0, seq, strobes, pulses);
        check_val("bfd_seq", 32'(seq), 32'b010010110);
        check_val("bfd_strobes", 32'(strobes), 11);
        check_val("bfd_brs", 32'(pulses), 0);

        run_frame(1, 0, 1, 1, 0, 4'd3, 1, 32'd0, 0, seq, strobes, pulses);
        check_val("nofd_seq", 32'(seq[5:0]), 32'b000011);
        check_val("nofd_brs", 32'(pulses), 0);

        enable = 1'b0;
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        enable = 1'b1;
        check_val("en_busy", 32'(bz[0]), 0);
        tick();
        check_idle(0, "en_idle");

        run_frame(0, 0, 0, 0, 0, 4'hC, 1, 32'd0, 3, seq, strobes, pulses);
        reset_n = 1'b0;
        #1;
        check_idle(0, "midrst");
        tick();
        check_idle(0, "midrst_hold");
        reset_n = 1'b1;
        tick();
        run_frame(0, 0, 0, 0, 0, 4'd1, 1, 32'd0, 0, seq, strobes, pulses);
        check_val("after_rst_seq", 32'(seq[5:0]), 32'b000001);

`ifdef CAN_CTRL_DLC_DECODE_EN
        run_frame(0, 0, 1, 0, 0, 4'd13, 1, 32'd0, 0, seq, strobes, pulses);
        check_val("db_fd13", 32'(db[0]), 32);
        run_frame(0, 0, 0, 0, 0, 4'd13, 1, 32'd0, 0, seq, strobes, pulses);
        check_val("db_cl13", 32'(db[0]), 8);
`endif

        for (int n = 0; n < 40; n++) begin
            run_frame(int'($urandom_range(0, 1)), 1'($urandom), 1'($urandom), 1'($urandom),
                      1'($urandom), 4'($urandom), 1'($urandom), $urandom, 0,
                      seq, strobes, pulses);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/can_control_field_tx.md
Name: can_control_field_tx

Overview:
Parametrised serializer for the CAN control field, successor to the classic 6-bit control-field block. It supports base/extended and classic/FD formats, with a variable field length of 6, 8 or 9 bits. It sits between the arbitration-field serializer (which pulses start) and the data-field serializer (which waits for control_complete). It also flags the bit-rate-switch point to the bit-timing logic.

Parameters:
FD_SUPPORT, 1, 1 = FD formats available; 0 = fdf input ignored and treated as 0
IDX_W, 4, width of bit_index output; must be >= 4

Ports:
clock  input  1  system clock
reset_n  input  1  asynchronous reset, active-low
enable  input  1  synchronous clear when low: all state and outputs return to reset values
start  input  1  one-cycle pulse from arbitration block: latch frame attributes, begin field
sample_point  input  1  one-cycle strobe per nominal bit time
stuff_bit_inserted  input  1  current bit on the bus is a stuff bit; do not advance
ide  input  1  0 = base frame, 1 = extended frame
fdf  input  1  1 = FD frame
brs  input  1  bit-rate switch requested (FD only)
esi  input  1  error-state indicator: 1 = error passive (FD only)
dlc  input  4  data length code
control_bit  output  1  current transmitted control-field bit
bit_index  output  IDX_W  index of bit currently driven, 0-based
busy  output  1  high in LOAD and SHIFT
brs_switch  output  1  one-cycle pulse: BRS bit completed with brs=1
control_complete  output  1  one-cycle pulse: last control bit sampled

Behaviour:
- Reset (async) and enable=0 (sync): state IDLE; control_bit=1; bit_index=0; busy=0; brs_switch=0; control_complete=0; shift register all 1s.
- Attributes (ide, fdf, brs, esi, dlc) are sampled only on the start cycle. Later changes have no effect on the field in progress.
- Field sequences, sent left to right with DLC MSB first; eff_fdf = fdf & FD_SUPPORT:
  - base classic, 6 bits: IDE=0, r0=0, DLC[3:0]
  - extended classic, 6 bits: r1=0, r0=0, DLC[3:0]
  - base FD, 9 bits: IDE=0, FDF=1, res=0, BRS, ESI, DLC[3:0]
  - extended FD, 8 bits: FDF=1, res=0, BRS, ESI, DLC[3:0]
- The length register holds 6, 8 or 9.
- State machine:
  - IDLE: waits for start; start -> LOAD.
  - LOAD: 1 cycle; loads the 9-bit left-aligned shift register and length; control_bit <= first bit; bit_index <= 0; -> SHIFT.
  - SHIFT: advance = sample_point & !stuff_bit_inserted.
    - On advance with bit_index < len-1: shift left with 1 fill; control_bit <= next bit; bit_index++.
    - On advance with bit_index == len-1: -> DONE, control_complete <= 1.
    - Without advance, all outputs hold.
  - DONE: 1 cycle; control_bit=1; control_complete deasserts; -> IDLE.
- Latency: control_bit valid 2 cycles after start. control_complete is registered and asserts the cycle after the final qualifying sample_point, for exactly one cycle.
- brs_switch is registered, one cycle wide. It asserts the cycle after the advance on the BRS bit position (index 3 base FD, index 2 extended FD) if the latched brs=1. It never asserts in classic frames or when FD_SUPPORT=0.
- start while busy or in DONE: ignored.
- sample_point together with stuff_bit_inserted: no advance, no pulse.
- start together with enable=0: enable wins; stays IDLE.
- reset mid-field: immediate return to IDLE values; no complete pulse.
- busy is low in DONE.

Optional Feature:
Macro CAN_CTRL_DLC_DECODE_EN.
- With it: adds output data_bytes [6:0], latched in LOAD and held until the next LOAD; 0 after reset.
  - Classic frames: min(dlc,8).
  - FD frames: DLC 0-8 -> 0-8; 9->12, 10->16, 11->20, 12->24, 13->32, 14->48, 15->64.
- Without it: port absent; no decode logic.

Test Plan:
- Base classic, ide=0 fdf=0 dlc=4'b1010, six clean sample_points -> control_bit sequence 0,0,1,0,1,0; control_complete pulses once after the 6th; brs_switch never asserts.
- Extended FD, ide=1 fdf=1 brs=1 esi=0 dlc=4'hF -> sequence 1,0,1,0,1,1,1,1 (8 bits); brs_switch pulses once after the 3rd advance; complete after the 8th.
- Base FD, brs=0, with stuff_bit_inserted=1 on the 2nd and 5th sample_points -> 9 bits still sent, bit_index holds across stuffed strobes, 11 strobes total to complete, no brs_switch.
- FD_SUPPORT=0 instance, fdf=1 ide=0 dlc=3 -> classic 6-bit field 0,0,0,0,1,1; no brs_switch.
- reset_n low after 3 bits, then start again with dlc=1 -> outputs return to reset values immediately; the new field starts from index 0 and completes normally; a start pulse while busy is ignored.
- With CAN_CTRL_DLC_DECODE_EN: FD dlc=13 -> data_bytes=32; classic dlc=13 -> data_bytes=8.
